spi_sensor_responder: RTL and testbench



---
 rtl/spi_sensor_responder_pkg.sv | 47 ++++
 rtl/spi_sensor_responder_if.sv | 11 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_sensor_responder.sv | 188 ++++++++++++++++++
 tb/tb_spi_sensor_responder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_sensor_responder_pkg.sv
// Shared definitions for the SPI sensor responder: register map, reset constants, FSM states.
package spi_sensor_responder_pkg;

    localparam logic [6:0] AddrDevid    = 7'h00;
    localparam logic [6:0] AddrStatus   = 7'h04;
    localparam logic [6:0] AddrTemp2    = 7'h06;
    localparam logic [6:0] AddrTemp1    = 7'h07;
    localparam logic [6:0] AddrXdata3   = 7'h08;
    localparam logic [6:0] AddrXdata2   = 7'h09;
    localparam logic [6:0] AddrXdata1   = 7'h0A;
    localparam logic [6:0] AddrYdata3   = 7'h0B;
    localparam logic [6:0] AddrYdata2   = 7'h0C;
    localparam logic [6:0] AddrYdata1   = 7'h0D;
    localparam logic [6:0] AddrZdata3   = 7'h0E;
    localparam logic [6:0] AddrZdata2   = 7'h0F;
    localparam logic [6:0] AddrZdata1   = 7'h10;
    localparam logic [6:0] AddrFilter   = 7'h28;
    localparam logic [6:0] AddrPowerCtl = 7'h2D;

    localparam logic [7:0] DevidValue    = 8'hAD;
    localparam logic [7:0] PowerCtlReset = 8'h01;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData
    } spi_state_e;

    typedef struct packed {
        logic [19:0] x;
        logic [19:0] y;
        logic [19:0] z;
        logic [11:0] temp;
    } sample_t;

    // Byte idx 0/1/2 of a 20-bit axis: [19:12], [11:4], {[3:0], 4'b0}.
    function automatic logic [7:0] axis_byte(input logic [19:0] v, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = v[19:12];
            2'd1:    b = v[11:4];
            default: b = {v[3:0], 4'b0000};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_sensor_responder_if.sv
// SPI pad-side bundle between the initiator (master) and the sensor responder (slave).
interface spi_sensor_responder_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with rise/fall detection on the synchronised level.
module spi_sync_edge #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] settle_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q   <= ResetVal;
            sync_q   <= ResetVal;
            prev_q   <= ResetVal;
            settle_q <= 2'd0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
        end
    end

    // Edges are suppressed until the chain holds real pin samples, so a pin
    // already low at reset release is not mistaken for a falling edge.
    assign sync = sync_q;
    assign rise = (settle_q == 2'd3) && sync_q && !prev_q;
    assign fall = (settle_q == 2'd3) && !sync_q && prev_q;

endmodule

// File: rtl/spi_sensor_responder.sv
// SPI mode-0 responder emulating the accelerometer register file.
// Define SPI_RESP_SHADOW_EN to serve 0x06-0x10 from a snapshot taken when 0x08 is read.
module spi_sensor_responder
    import spi_sensor_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    spi_sensor_responder_if.slave spi,
    input  logic                  sample_valid,
    input  logic [19:0]           x_in,
    input  logic [19:0]           y_in,
    input  logic [19:0]           z_in,
    input  logic [11:0]           temp_in,
    output logic [7:0]            filter_cfg,
    output logic [7:0]            power_ctl
);
    logic sclk_rise, sclk_fall, unused_sclk_sync;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_meta_q, mosi_sync_q;

    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d, addr_q, addr_d, rd_addr;
    logic [7:0] tx_q, tx_d, filter_q, filter_d, power_q, power_d, rd_byte, rx_byte;
    logic       rnw_q, rnw_d, miso_q, miso_d, oe_q, data_rdy_q, data_rdy_d;
    logic       rd_load, rd_x08, capture;
    sample_t    live_q, rd_sample;

    spi_sync_edge #(.ResetVal(1'b0)) u_sclk_sync (
        .clk (clk),
        .rst (rst),
        .din (spi.sclk),
        .sync(unused_sclk_sync),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    spi_sync_edge #(.ResetVal(1'b1)) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .din (spi.cs_n),
        .sync(cs_sync),
        .rise(cs_rise),
        .fall(cs_fall)
    );

    assign rx_byte = {rx_q, mosi_sync_q};
    assign rd_addr = (state_q == StCmd) ? rx_q : addr_q + 7'd1;
    assign rd_load = sclk_rise && (bit_cnt_q == 3'd7) &&
                     (((state_q == StCmd) && mosi_sync_q) || ((state_q == StData) && rnw_q));
    assign rd_x08  = rd_load && (rd_addr == AddrXdata3);
    assign capture = sample_valid && !power_q[0];

`ifdef SPI_RESP_SHADOW_EN
    sample_t shadow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) shadow_q <= '0;
        else if (rd_x08) shadow_q <= live_q;
    end

    // The 0x08 byte is read in the same cycle the snapshot is taken.
    assign rd_sample = (rd_addr == AddrXdata3) ? live_q : shadow_q;
`else
    assign rd_sample = live_q;
`endif

    always_comb begin
        rd_byte = 8'h00;
        case (rd_addr)
            AddrDevid:    rd_byte = DevidValue;
            AddrStatus:   rd_byte = {7'b0, data_rdy_q};
            AddrTemp2:    rd_byte = {4'b0, rd_sample.temp[11:8]};
            AddrTemp1:    rd_byte = rd_sample.temp[7:0];
            AddrXdata3:   rd_byte = axis_byte(rd_sample.x, 2'd0);
            AddrXdata2:   rd_byte = axis_byte(rd_sample.x, 2'd1);
            AddrXdata1:   rd_byte = axis_byte(rd_sample.x, 2'd2);
            AddrYdata3:   rd_byte = axis_byte(rd_sample.y, 2'd0);
            AddrYdata2:   rd_byte = axis_byte(rd_sample.y, 2'd1);
            AddrYdata1:   rd_byte = axis_byte(rd_sample.y, 2'd2);
            AddrZdata3:   rd_byte = axis_byte(rd_sample.z, 2'd0);
            AddrZdata2:   rd_byte = axis_byte(rd_sample.z, 2'd1);
            AddrZdata1:   rd_byte = axis_byte(rd_sample.z, 2'd2);
            AddrFilter:   rd_byte = filter_q;
            AddrPowerCtl: rd_byte = power_q;
            default:      rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        addr_d    = addr_q;
        rnw_d     = rnw_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        filter_d  = filter_q;
        power_d   = power_q;
        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = StCmd;
                    bit_cnt_d = 3'd0;
                end
            end
            StCmd: begin
                miso_d = 1'b0;
                if (sclk_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d  = rx_q;
                        rnw_d   = mosi_sync_q;
                        tx_d    = mosi_sync_q ? rd_byte : 8'h00;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (sclk_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d = addr_q + 7'd1;
                        if (rnw_q) begin
                            tx_d = rd_byte;
                        end else if (addr_q == AddrFilter) begin
                            filter_d = rx_byte;
                        end else if (addr_q == AddrPowerCtl) begin
                            power_d = rx_byte;
                        end
                    end
                end
                if (sclk_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
            default: state_d = StIdle;
        endcase
        if (cs_rise) state_d = StIdle;
    end

    // A set in the same cycle as the 0x08 read clear wins.
    assign data_rdy_d = capture || (data_rdy_q && !rd_x08);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            addr_q      <= 7'd0;
            rnw_q       <= 1'b0;
            tx_q        <= 8'h00;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            filter_q    <= 8'h00;
            power_q     <= PowerCtlReset;
            data_rdy_q  <= 1'b0;
            live_q      <= '0;
        end else begin
            mosi_meta_q <= spi.mosi;
            mosi_sync_q <= mosi_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            oe_q        <= !cs_sync;
            filter_q    <= filter_d;
            power_q     <= power_d;
            data_rdy_q  <= data_rdy_d;
            if (capture) live_q <= {x_in, y_in, z_in, temp_in};
        end
    end

    assign spi.miso    = miso_q;
    assign spi.miso_oe = oe_q;
    assign filter_cfg  = filter_q;
    assign power_ctl   = power_q;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Self-checking bench for spi_sensor_responder: directed scenarios plus randomized traffic
// against a register-level reference model.
module tb_spi_sensor_responder;

    localparam int H = 8;  // sclk half period in clk cycles

    logic        clk, rst;
    logic        sample_valid;
    logic [19:0] x_in, y_in, z_in;
    logic [11:0] temp_in;
    logic [7:0]  filter_cfg, power_ctl;

    spi_sensor_responder_if bus ();

    spi_sensor_responder dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (bus),
        .sample_valid(sample_valid),
        .x_in        (x_in),
        .y_in        (y_in),
        .z_in        (z_in),
        .temp_in     (temp_in),
        .filter_cfg  (filter_cfg),
        .power_ctl   (power_ctl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  tx_bytes [8];
    logic [7:0]  rx_bytes [8];
    logic [7:0]  exp_bytes[8];
    logic [7:0]  cmd_rx;
    logic        oe_low_in_frame;
    int          mid_byte = -1;
    logic [19:0] mid_x, mid_y, mid_z;
    logic [11:0] mid_t;

    // Reference model: sensor register file as seen from the SPI side.
    logic [19:0] m_x, m_y, m_z;
    logic [11:0] m_t;
    logic        m_rdy;
    logic [7:0]  m_filter, m_power;
`ifdef SPI_RESP_SHADOW_EN
    logic [19:0] s_x, s_y, s_z;
    logic [11:0] s_t;
`endif

    function automatic logic [7:0] axis(input logic [19:0] v, input int k);
        if (k == 0) return 8'(v >> 12);
        if (k == 1) return 8'((v >> 4) & 20'hFF);
        return 8'((v & 20'hF) << 4);
    endfunction

    task automatic m_reset();
        m_x = 0; m_y = 0; m_z = 0; m_t = 0; m_rdy = 0; m_filter = 8'h00; m_power = 8'h01;
`ifdef SPI_RESP_SHADOW_EN
        s_x = 0; s_y = 0; s_z = 0; s_t = 0;
`endif
    endtask

    task automatic m_sample(input logic [19:0] x, y, z, input logic [11:0] t);
        if (m_power[0] == 1'b0) begin
            m_x = x; m_y = y; m_z = z; m_t = t; m_rdy = 1'b1;
        end
    endtask

    // Byte the responder will serve when it decodes a read of address a.
    function automatic logic [7:0] m_decode(input logic [6:0] a);
        logic [19:0] vx, vy, vz;
        logic [11:0] vt;
        int ai;
        ai = int'(a);
        if (ai == 8) m_rdy = 1'b0;
`ifdef SPI_RESP_SHADOW_EN
        if (ai == 8) begin s_x = m_x; s_y = m_y; s_z = m_z; s_t = m_t; end
        vx = s_x; vy = s_y; vz = s_z; vt = s_t;
`else
        vx = m_x; vy = m_y; vz = m_z; vt = m_t;
`endif
        if (ai == 8'h00) return 8'hAD;
        if (ai == 8'h04) return (ai == 8) ? 8'h00 : {7'b0, m_rdy};
        if (ai == 8'h06) return 8'(vt >> 8);
        if (ai == 8'h07) return 8'(vt & 12'hFF);
        if (ai >= 8'h08 && ai <= 8'h0A) return axis(vx, ai - 8);
        if (ai >= 8'h0B && ai <= 8'h0D) return axis(vy, ai - 11);
        if (ai >= 8'h0E && ai <= 8'h10) return axis(vz, ai - 14);
        if (ai == 8'h28) return m_filter;
        if (ai == 8'h2D) return m_power;
        return 8'h00;
    endfunction

    task automatic m_read(input logic [6:0] start, input int n);
        for (int i = 0; i < n; i++) exp_bytes[i] = m_decode(start + 7'(i));
        void'(m_decode(start + 7'(n)));  // the responder pre-loads the next address
    endtask

    task automatic m_write(input logic [6:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            if (start + 7'(i) == 7'h28) m_filter = tx_bytes[i];
            if (start + 7'(i) == 7'h2D) m_power = tx_bytes[i];
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sample(input logic [19:0] x, y, z, input logic [11:0] t);
        x_in = x; y_in = y; z_in = z; temp_in = t;
        sample_valid = 1'b1;
        m_sample(x, y, z, t);
        wait_clks(1);
        sample_valid = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = b[7-i];
            wait_clks(H);
            r = {r[6:0], bus.miso};
            if (bus.miso_oe !== 1'b1) oe_low_in_frame = 1'b1;
            bus.sclk = 1'b1;
            wait_clks(H);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int n);
        oe_low_in_frame = 1'b0;
        bus.cs_n = 1'b0;
        wait_clks(H);
        spi_bits(cmd, 8, cmd_rx);
        for (int i = 0; i < n; i++) begin
            if (i == mid_byte) pulse_sample(mid_x, mid_y, mid_z, mid_t);
            spi_bits(tx_bytes[i], 8, rx_bytes[i]);
        end
        wait_clks(H);
        bus.cs_n = 1'b1;
        wait_clks(2 * H);
    endtask

    task automatic test_reset();
        if (bus.miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", bus.miso); end
        n_cmp++;
        if (bus.miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", bus.miso_oe); end
        n_cmp++;
        if (filter_cfg !== 8'h00) begin n_bad++; $display("FAIL reset_filter: got %h want 00", filter_cfg); end
        n_cmp++;
        if (power_ctl !== 8'h01) begin n_bad++; $display("FAIL reset_power: got %h want 01", power_ctl); end
        n_cmp++;
    endtask

    task automatic test_standby();
        pulse_sample(20'hABCDE, 20'h13579, 20'h2468A, 12'h5A5);
        tx_bytes[0] = 8'h00;
        spi_frame(8'h09, 1);
        m_read(7'h04, 1);
        if (rx_bytes[0] !== 8'h00 || rx_bytes[0] !== exp_bytes[0]) begin
            n_bad++; $display("FAIL standby_status: got %h want 00", rx_bytes[0]);
        end
        n_cmp++;
        spi_frame(8'h11, 1);
        m_read(7'h08, 1);
        if (rx_bytes[0] !== 8'h00 || rx_bytes[0] !== exp_bytes[0]) begin
            n_bad++; $display("FAIL standby_xdata3: got %h want 00", rx_bytes[0]);
        end
        n_cmp++;
    endtask

    task automatic test_devid();
        tx_bytes[0] = 8'h00;
        spi_frame(8'h01, 1);
        m_read(7'h00, 1);
        if (rx_bytes[0] !== 8'hAD || rx_bytes[0] !== exp_bytes[0]) begin
            n_bad++; $display("FAIL devid: got %h want ad", rx_bytes[0]);
        end
        n_cmp++;
        if (cmd_rx !== 8'h00) begin n_bad++; $display("FAIL miso_during_cmd: got %h want 00", cmd_rx); end
        n_cmp++;
        if (oe_low_in_frame !== 1'b0) begin n_bad++; $display("FAIL oe_in_frame: got low want high"); end
        n_cmp++;
        if (bus.miso_oe !== 1'b0) begin n_bad++; $display("FAIL oe_after_frame: got %b want 0", bus.miso_oe); end
        n_cmp++;
    endtask

    task automatic test_sample_burst();
        logic [7:0] want [3];
        want[0] = 8'h12; want[1] = 8'h34; want[2] = 8'h50;
        tx_bytes[0] = 8'h00;
        spi_frame(8'h5A, 1);
        m_write(7'h2D, 1);
        if (power_ctl !== 8'h00) begin n_bad++; $display("FAIL power_write: got %h want 00", power_ctl); end
        n_cmp++;
        pulse_sample(20'h12345, 20'($urandom), 20'($urandom), 12'($urandom));
        spi_frame(8'h09, 1);
        m_read(7'h04, 1);
        if (rx_bytes[0] !== 8'h01) begin n_bad++; $display("FAIL status_set: got %h want 01", rx_bytes[0]); end
        n_cmp++;
        for (int i = 0; i < 3; i++) tx_bytes[i] = 8'h00;
        spi_frame(8'h11, 3);
        m_read(7'h08, 3);
        for (int i = 0; i < 3; i++) begin
            if (rx_bytes[i] !== want[i] || rx_bytes[i] !== exp_bytes[i]) begin
                n_bad++; $display("FAIL x_burst[%0d]: got %h want %h", i, rx_bytes[i], want[i]);
            end
            n_cmp++;
        end
        spi_frame(8'h09, 1);
        m_read(7'h04, 1);
        if (rx_bytes[0] !== 8'h00) begin n_bad++; $display("FAIL status_clr: got %h want 00", rx_bytes[0]); end
        n_cmp++;
    endtask

    task automatic test_shadow();
        logic [7:0] want [3];
`ifdef SPI_RESP_SHADOW_EN
        want[0] = 8'h24; want[1] = 8'h68; want[2] = 8'hA0;
`else
        want[0] = 8'h24; want[1] = 8'h68; want[2] = 8'h10;
`endif
        pulse_sample(20'h2468A, 20'($urandom), 20'($urandom), 12'($urandom));
        mid_x = 20'h11111; mid_y = 20'($urandom); mid_z = 20'($urandom); mid_t = 12'($urandom);
        mid_byte = 1;
        exp_bytes[0] = m_decode(7'h08);
        exp_bytes[1] = m_decode(7'h09);
        for (int i = 0; i < 3; i++) tx_bytes[i] = 8'h00;
        spi_frame(8'h11, 3);
        mid_byte = -1;
        exp_bytes[2] = m_decode(7'h0A);
        void'(m_decode(7'h0B));
        for (int i = 0; i < 3; i++) begin
            if (rx_bytes[i] !== want[i] || rx_bytes[i] !== exp_bytes[i]) begin
                n_bad++; $display("FAIL mid_burst[%0d]: got %h want %h", i, rx_bytes[i], want[i]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_write_burst();
        logic [7:0] r;
        tx_bytes[0] = 8'h05; tx_bytes[1] = 8'h07;
        spi_frame(8'h50, 2);
        m_write(7'h28, 2);
        if (filter_cfg !== 8'h05) begin n_bad++; $display("FAIL filter_write: got %h want 05", filter_cfg); end
        n_cmp++;
        tx_bytes[0] = 8'h00;
        spi_frame(8'h53, 1);
        m_read(7'h29, 1);
        if (rx_bytes[0] !== 8'h00) begin n_bad++; $display("FAIL unmapped_29: got %h want 00", rx_bytes[0]); end
        n_cmp++;
        // Four bits of a POWER_CTL write, then deselect.
        bus.cs_n = 1'b0;
        wait_clks(H);
        spi_bits(8'h5A, 8, r);
        spi_bits(8'hF0, 4, r);
        wait_clks(H);
        bus.cs_n = 1'b1;
        wait_clks(2 * H);
        if (power_ctl !== m_power) begin
            n_bad++; $display("FAIL partial_write: got %h want %h", power_ctl, m_power);
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] r;
        tx_bytes[0] = 8'h33;
        spi_frame(8'h50, 1);
        m_write(7'h28, 1);
        bus.cs_n = 1'b0;
        wait_clks(H);
        spi_bits(8'h01, 8, r);
        spi_bits(8'h00, 3, r);
        rst = 1'b0;
        #1;
        if (bus.miso_oe !== 1'b0) begin n_bad++; $display("FAIL oe_in_reset: got %b want 0", bus.miso_oe); end
        n_cmp++;
        if (bus.miso !== 1'b0) begin n_bad++; $display("FAIL miso_in_reset: got %b want 0", bus.miso); end
        n_cmp++;
        wait_clks(3);
        if (filter_cfg !== 8'h00) begin n_bad++; $display("FAIL filter_in_reset: got %h want 00", filter_cfg); end
        n_cmp++;
        rst = 1'b1;
        m_reset();
        spi_bits(8'hFF, 5, r);
        if (r !== 8'h00) begin n_bad++; $display("FAIL miso_after_abort: got %h want 00", r); end
        n_cmp++;
        wait_clks(H);
        bus.cs_n = 1'b1;
        wait_clks(2 * H);
        tx_bytes[0] = 8'h00;
        spi_frame(8'h5B, 1);
        m_read(7'h2D, 1);
        if (rx_bytes[0] !== 8'h01 || rx_bytes[0] !== exp_bytes[0]) begin
            n_bad++; $display("FAIL power_after_reset: got %h want 01", rx_bytes[0]);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        logic [6:0] start;
        int n;
        for (int op = 0; op < 30; op++) begin
            case ($urandom_range(0, 3))
                0: pulse_sample(20'($urandom), 20'($urandom), 20'($urandom), 12'($urandom));
                1: begin
                    case ($urandom_range(0, 3))
                        0: start = 7'h28;
                        1: start = 7'h2C;
                        2: start = 7'h2D;
                        default: start = 7'h08;
                    endcase
                    n = $urandom_range(1, 2);
                    for (int i = 0; i < n; i++) tx_bytes[i] = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) tx_bytes[n-1][0] = 1'b0;
                    spi_frame({start, 1'b0}, n);
                    m_write(start, n);
                end
                2: begin
                    case ($urandom_range(0, 7))
                        0: start = 7'h00;
                        1: start = 7'h04;
                        2: start = 7'h06;
                        3: start = 7'h08;
                        4: start = 7'h0C;
                        5: start = 7'h0F;
                        6: start = 7'h27;
                        default: start = 7'h7E;
                    endcase
                    n = $urandom_range(1, 4);
                    for (int i = 0; i < n; i++) tx_bytes[i] = 8'($urandom);
                    spi_frame({start, 1'b1}, n);
                    m_read(start, n);
                    for (int i = 0; i < n; i++) begin
                        if (rx_bytes[i] !== exp_bytes[i]) begin
                            n_bad++;
                            $display("FAIL rand_read @%h+%0d: got %h want %h",
                                     start, i, rx_bytes[i], exp_bytes[i]);
                        end
                        n_cmp++;
                    end
                end
                default: begin
                    if (filter_cfg !== m_filter || power_ctl !== m_power) begin
                        n_bad++;
                        $display("FAIL rand_regs: got %h/%h want %h/%h",
                                 filter_cfg, power_ctl, m_filter, m_power);
                    end
                    n_cmp++;
                end
            endcase
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        sample_valid = 1'b0;
        x_in = '0; y_in = '0; z_in = '0; temp_in = '0;
        m_reset();
        wait_clks(5);
        rst = 1'b1;
        wait_clks(5);
        test_reset();
        test_standby();
        test_devid();
        test_sample_burst();
        test_shadow();
        test_write_burst();
        test_reset_mid_frame();
        tx_bytes[0] = 8'h00;
        spi_frame(8'h5A, 1);
        m_write(7'h2D, 1);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
